// File: rtl/vga_sync_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vga_sync_monitor                                           |
// | Brief   : Receive-side VGA monitor. Recovers pixel position from     |
// |           hsync/vsync, checks sync timing, tracks lock and produces  |
// |           a 16-bit per-frame pixel checksum.                         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module vga_sync_monitor #(
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int VS_HPOS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [5:0]  i_rgb,
  output logic [9:0]  o_sx,
  output logic [9:0]  o_sy,
  output logic        o_de,
  output logic [5:0]  o_rgb_out,
  output logic        o_locked,
  output logic        o_frame_valid,
  output logic [15:0] o_frame_sum,
  output logic [7:0]  o_err_count
);

  localparam int         c_H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
  localparam int         c_V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_EXP    = 10'(H_RES + H_FP);
  localparam logic [9:0] c_H_RESYNC = 10'(H_RES + H_FP + 1);
  localparam logic [9:0] c_V_EXP    = 10'(V_RES + V_FP);
  localparam logic [9:0] c_VS_HPOS  = 10'(VS_HPOS);
  localparam logic [9:0] c_H_ACT    = 10'(H_RES);
  localparam logic [9:0] c_V_ACT    = 10'(V_RES);
  localparam logic       c_HS_ON    = (H_POL != 0);
  localparam logic       c_VS_ON    = (V_POL != 0);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_hs1, r_hs1_d, r_vs1, r_vs1_d;
  logic [5:0]  r_rgb1;
  logic [9:0]  r_h_pos, r_v_pos, w_h_nxt, w_v_nxt;
  logic        r_clean, w_clean_nxt, w_fv;
  logic [15:0] r_acc, w_acc_add;
  logic [7:0]  r_err_count;

  // Edge, expected-point and error decode on the stage-1 sample.
  logic w_h_edge, w_v_edge, w_h_exp, w_v_exp, w_h_wrap, w_v_wrap;
  logic w_frame_end, w_err, w_active, w_de;
  assign w_h_edge    = (r_hs1 == c_HS_ON) && (r_hs1_d != c_HS_ON);
  assign w_v_edge    = (r_vs1 == c_VS_ON) && (r_vs1_d != c_VS_ON);
  assign w_h_exp     = (r_h_pos == c_H_EXP);
  assign w_v_exp     = (r_v_pos == c_V_EXP) && (r_h_pos == c_VS_HPOS);
  assign w_h_wrap    = (r_h_pos == c_H_LAST);
  assign w_v_wrap    = (r_v_pos == c_V_LAST);
  assign w_frame_end = w_h_wrap && w_v_wrap;
  assign w_err       = (r_state != ST_UNLOCKED) &&
                       ((w_h_edge != w_h_exp) || (w_v_edge != w_v_exp));
  assign w_active    = (r_h_pos < c_H_ACT) && (r_v_pos < c_V_ACT);
  assign w_de        = w_active && (r_state == ST_LOCKED);
  assign w_acc_add   = w_active ? (r_acc + {10'd0, r_rgb1}) : r_acc;
  assign o_locked    = (r_state == ST_LOCKED);
  assign o_err_count = r_err_count;

  // Stage 1: sample the pins and keep the previous sync samples for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1   <= ~c_HS_ON;
      r_hs1_d <= ~c_HS_ON;
      r_vs1   <= ~c_VS_ON;
      r_vs1_d <= ~c_VS_ON;
      r_rgb1  <= '0;
    end else begin
      r_hs1   <= i_hsync;
      r_hs1_d <= r_hs1;
      r_vs1   <= i_vsync;
      r_vs1_d <= r_vs1;
      r_rgb1  <= i_rgb;
    end
  end

  // Position counters: free-run, but an early or unexpected sync edge pulls them onto the source.
  always_comb begin
    w_h_nxt = r_h_pos + 10'd1;
    if (w_h_edge && !w_h_exp) begin
      w_h_nxt = c_H_RESYNC;
    end else if (w_h_wrap) begin
      w_h_nxt = '0;
    end
    w_v_nxt = r_v_pos;
    if (w_v_edge && !w_v_exp) begin
      w_v_nxt = c_V_EXP;
    end else if (w_h_wrap) begin
      w_v_nxt = w_v_wrap ? 10'd0 : (r_v_pos + 10'd1);
    end
  end

  // Lock FSM next state; the clean flag records an error-free run inside ACQUIRE.
  always_comb begin
    w_state_nxt = r_state;
    w_clean_nxt = r_clean;
    w_fv        = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_v_edge) begin
          w_state_nxt = ST_ACQUIRE;
          w_clean_nxt = 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (w_err) begin
          w_clean_nxt = 1'b0;
        end
        if (w_frame_end) begin
          if (r_clean && !w_err) begin
            w_state_nxt = ST_LOCKED;
          end
          w_clean_nxt = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_err) begin
          w_state_nxt = ST_ACQUIRE;
          w_clean_nxt = 1'b1;
        end else if (w_frame_end) begin
          w_fv = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
      end
    endcase
  end

  // State, counters, checksum and error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_UNLOCKED;
      r_clean       <= 1'b0;
      r_h_pos       <= '0;
      r_v_pos       <= '0;
      r_acc         <= '0;
      r_err_count   <= '0;
      o_frame_sum   <= '0;
      o_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_clean       <= w_clean_nxt;
      r_h_pos       <= w_h_nxt;
      r_v_pos       <= w_v_nxt;
      r_acc         <= (w_frame_end || (w_state_nxt != r_state)) ? 16'd0 : w_acc_add;
      o_frame_valid <= w_fv;
      if (w_fv) begin
        o_frame_sum <= w_acc_add;
      end
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // Stage 2: position, enable and blanked pixel aligned to each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sx      <= '0;
      o_sy      <= '0;
      o_de      <= 1'b0;
      o_rgb_out <= '0;
    end else begin
      o_sx      <= r_h_pos;
      o_sy      <= r_v_pos;
      o_de      <= w_de;
      o_rgb_out <= w_de ? r_rgb1 : 6'd0;
    end
  end

endmodule
`default_nettype wire
